// File: rtl/dino_pkg.sv
// ---------------------------------------------------------------------------
// dino_pkg
// Shared constants and types for the game's background/obstacle renderers.
//   COLOR_CLOUD / COLOR_SKY : 12-bit RGB colours for cloud foreground and sky
//   SCREEN_COLS / SCREEN_ROWS : visible display geometry
//   LFSR_MASK  : feedback mask of the 16-bit Galois LFSR used by the spawners
//   spawn_state_t : spawn FSM states shared by the cloud and obstacle spawners
//   lfsr_next  : one Galois LFSR step
// ---------------------------------------------------------------------------
package dino_pkg;

   localparam logic [11:0] COLOR_CLOUD = 12'hfa2;
   localparam logic [11:0] COLOR_SKY   = 12'hfff;

   localparam int SCREEN_COLS = 640;
   localparam int SCREEN_ROWS = 480;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_SPAWN = 2'd2
   } spawn_state_t;

   // Galois form: shift right, and fold the mask in whenever a 1 falls out.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] nxt;
      nxt = cur >> 1;
      if (cur[0]) begin
         nxt = nxt ^ LFSR_MASK;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR used as the pseudo-random source of the spawners.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, loads SEED
//   step  : advance the sequence by one step when high
//   state : current LFSR contents
// SEED must be nonzero, otherwise the sequence locks at zero.
// ---------------------------------------------------------------------------
module lfsr16
   import dino_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [15:0] state
);

   // The register only moves on step so every consumer sees a value that is
   // stable across the whole frame between two steps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/cloud_layer.sv
// ---------------------------------------------------------------------------
// cloud_layer
// Background cloud layer of the VGA pixel stream. Owns N_CLOUD cloud slots,
// scrolls them left once per frame, spawns new clouds at the right edge at a
// fixed frame interval and retires them when they leave on the left.
// Rendering addresses an external 1-bit cloud bitmap ROM with a two-stage
// pipeline (row/col -> rom_addr -> d_out/opaque).
// Ports:
//   clk         : pixel/system clock
//   rst         : asynchronous active-high reset
//   enable      : game running; low freezes scrolling and spawning
//   frame_tick  : one-cycle pulse per frame, advances scrolling/spawning
//   row, col    : current scan position
//   rom_addr    : registered bitmap ROM address
//   rom_data    : ROM output bit for the address presented one clock earlier
//   d_out       : registered 12-bit pixel colour
//   opaque      : high when d_out is a cloud foreground pixel
//   active_mask : per-slot active bits
// ---------------------------------------------------------------------------
module cloud_layer
   import dino_pkg::*;
#(
   parameter int          N_CLOUD   = 4,
   parameter int          CLOUD_W   = 92,
   parameter int          CLOUD_H   = 27,
   parameter int          CLOUD_TOP = 200,
   parameter int          SCREEN_W  = SCREEN_COLS,
   parameter int          SPEED     = 1,
   parameter int          SPAWN_GAP = 120,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          ADDR_W    = 12,
   parameter logic [11:0] COLOR_FG  = COLOR_CLOUD,
   parameter logic [11:0] COLOR_BG  = COLOR_SKY
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               frame_tick,
   input  logic [8:0]         row,
   input  logic [9:0]         col,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic               rom_data,
   output logic [11:0]        d_out,
   output logic               opaque,
   output logic [N_CLOUD-1:0] active_mask
);

   localparam logic [10:0] X_SPAWN  = 11'(SCREEN_W + CLOUD_W);
   localparam logic [10:0] X_STEP   = 11'(SPEED);
   localparam logic [11:0] W_12     = 12'(CLOUD_W);
   localparam logic [9:0]  TOP_10   = 10'(CLOUD_TOP);
   localparam logic [9:0]  H_10     = 10'(CLOUD_H);
   localparam logic [ADDR_W-1:0] W_ADDR = ADDR_W'(CLOUD_W);
   localparam int          CNT_W    = $clog2(SPAWN_GAP + 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SPAWN_GAP - 1);

   logic [15:0]        lfsr_state;
   logic               lfsr_unused;
   logic [N_CLOUD-1:0] active;
   logic [N_CLOUD-1:0] free_slots;
   logic [N_CLOUD-1:0] spawn_pick;
   logic               spawn_fire;
   logic               scroll;
   spawn_state_t       spawn_state;
   logic [CNT_W-1:0]   gap_count;

   logic [N_CLOUD-1:0] slot_hit;
   logic [9:0]         row_off [N_CLOUD];
   logic [11:0]        col_off [N_CLOUD];

   logic               win_hit;
   logic [9:0]         win_row;
   logic [11:0]        win_col;
   logic [ADDR_W-1:0]  win_addr;
   logic               hit_q;

   // The LFSR keeps stepping while the game is paused so the sequence of
   // vertical offsets depends on how long the player waited.
   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .step  (frame_tick),
      .state (lfsr_state)
   );

   // Only the low five bits feed the vertical offset.
   assign lfsr_unused = ^lfsr_state[15:5];

   assign scroll      = frame_tick && enable;
   assign free_slots  = ~active;

   // Isolate the lowest set bit of free_slots: the lowest-index free slot.
   // Freedom comes from the registered active bits, so a slot retired on this
   // very tick only becomes claimable on the following clock.
   assign spawn_pick  = free_slots & (~free_slots + N_CLOUD'(1));
   assign spawn_fire  = enable && (spawn_state == S_SPAWN) && (|free_slots);
   assign active_mask = active;

   // Spawn scheduler: counts frame ticks between attempts, then sits in
   // S_SPAWN retrying every clock until a slot is free. Dropping enable parks
   // it in S_IDLE with the counter held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spawn_state <= S_IDLE;
         gap_count   <= '0;
      end else if (!enable) begin
         spawn_state <= S_IDLE;
      end else begin
         case (spawn_state)
            S_IDLE: begin
               spawn_state <= S_COUNT;
            end
            S_COUNT: begin
               if (frame_tick) begin
                  if (gap_count == GAP_LAST) begin
                     gap_count   <= '0;
                     spawn_state <= S_SPAWN;
                  end else begin
                     gap_count <= gap_count + CNT_W'(1);
                  end
               end
            end
            S_SPAWN: begin
               if (|free_slots) begin
                  spawn_state <= S_COUNT;
               end
            end
            default: begin
               spawn_state <= S_IDLE;
            end
         endcase
      end
   end

   // One block of state and hit-test logic per cloud slot.
   for (genvar i = 0; i < N_CLOUD; i++) begin : g_slot
      logic        active_q;
      logic [10:0] x_q;
      logic [4:0]  yoff_q;
      logic [9:0]  top;
      logic [9:0]  row_ext;
      logic [11:0] col_ext;
      logic [11:0] col_shift;
      logic [11:0] x_ext;

      // A freshly spawned slot cannot also be scrolling since it was free,
      // so spawn simply takes priority. x is the exclusive right edge; the
      // slot retires once it can no longer take a full step.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            active_q <= 1'b0;
            x_q      <= '0;
            yoff_q   <= '0;
         end else if (spawn_fire && spawn_pick[i]) begin
            active_q <= 1'b1;
            x_q      <= X_SPAWN;
            yoff_q   <= lfsr_state[4:0];
         end else if (scroll && active_q) begin
            if (x_q <= X_STEP) begin
               active_q <= 1'b0;
            end else begin
               x_q <= x_q - X_STEP;
            end
         end
      end

      assign active[i] = active_q;

      // The left edge x-CLOUD_W goes negative while a cloud slides off the
      // screen, so the column test is rearranged as col+CLOUD_W >= x to keep
      // everything non-negative and clip the visible part correctly.
      assign top       = TOP_10 + {5'd0, yoff_q};
      assign row_ext   = {1'b0, row};
      assign col_ext   = {2'b00, col};
      assign col_shift = col_ext + W_12;
      assign x_ext     = {1'b0, x_q};

      assign slot_hit[i] = active_q
                           && (row_ext >= top) && (row_ext < top + H_10)
                           && (col_ext < x_ext) && (col_shift >= x_ext);

      assign row_off[i] = row_ext - top;
      assign col_off[i] = col_shift - x_ext;
   end

   // Priority select: scanning from the top index down lets the lowest hit
   // index overwrite the others. Offsets are muxed first so a single constant
   // multiplier serves all slots.
   always_comb begin
      win_hit = 1'b0;
      win_row = '0;
      win_col = '0;
      for (int i = N_CLOUD - 1; i >= 0; i--) begin
         if (slot_hit[i]) begin
            win_hit = 1'b1;
            win_row = row_off[i];
            win_col = col_off[i];
         end
      end
   end

   // row_off < CLOUD_H and col_off < CLOUD_W on a hit, so the address always
   // lands inside the bitmap.
   assign win_addr = ADDR_W'(win_row) * W_ADDR + ADDR_W'(win_col);

   // Stage 1: register the ROM address of the winning slot. On a miss the
   // address is held so the ROM input does not toggle needlessly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr <= '0;
         hit_q    <= 1'b0;
      end else begin
         hit_q <= win_hit;
         if (win_hit) begin
            rom_addr <= win_addr;
         end
      end
   end

   // Stage 2: rom_data now belongs to the address registered in stage 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_out  <= COLOR_BG;
         opaque <= 1'b0;
      end else begin
         d_out  <= (hit_q && rom_data) ? COLOR_FG : COLOR_BG;
         opaque <= hit_q && rom_data;
      end
   end

endmodule

// File: tb/tb_cloud_layer.sv
// ---------------------------------------------------------------------------
// tb_cloud_layer
// Randomised bench for cloud_layer. A behavioural model of the cloud world
// (slot list, frame counter, random offsets) predicts every pixel; predicted
// pixels go into a scoreboard queue and a separate monitor compares them with
// the DUT output when they are due.
// ---------------------------------------------------------------------------
module tb_cloud_layer;

   localparam int NC   = 4;
   localparam int CW   = 92;
   localparam int CH   = 27;
   localparam int CTOP = 200;
   localparam int SW   = 640;
   localparam int SPD  = 2;
   localparam int GAP  = 40;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [11:0] FG   = 12'hfa2;
   localparam logic [11:0] BG   = 12'hfff;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          frame_tick;
   logic [8:0]    row;
   logic [9:0]    col;
   logic [11:0]   rom_addr;
   logic          rom_data;
   logic [11:0]   d_out;
   logic          opaque;
   logic [NC-1:0] active_mask;

   bit            rom_bits [4096];

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   typedef struct {
      int          due;
      logic [11:0] d;
      logic        o;
   } exp_t;

   exp_t          sb [$];

   // Reference world state.
   bit            m_on [NC];
   int            m_x [NC];
   int            m_y [NC];
   int            m_cnt;
   int            m_mode;
   logic [15:0]   m_lfsr;
   logic [11:0]   exp_addr;
   logic [NC-1:0] exp_mask;

   cloud_layer #(
      .N_CLOUD   (NC),
      .CLOUD_W   (CW),
      .CLOUD_H   (CH),
      .CLOUD_TOP (CTOP),
      .SCREEN_W  (SW),
      .SPEED     (SPD),
      .SPAWN_GAP (GAP),
      .LFSR_SEED (SEED),
      .ADDR_W    (12),
      .COLOR_FG  (FG),
      .COLOR_BG  (BG)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .frame_tick  (frame_tick),
      .row         (row),
      .col         (col),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .d_out       (d_out),
      .opaque      (opaque),
      .active_mask (active_mask)
   );

   always #5 clk = ~clk;

   // The bitmap ROM returns the bit for whatever address the DUT registered.
   assign rom_data = rom_bits[rom_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference model: advances the cloud world by one clock using the inputs
   // the DUT samples on the same edge, and predicts the pixel for this row/col.
   always @(posedge clk) begin : model
      int  hit_i;
      int  r;
      int  c;
      int  a;
      int  first_free;
      bit  pix;
      bit  do_spawn;
      if (rst) begin
         for (int i = 0; i < NC; i++) begin
            m_on[i] = 1'b0;
            m_x[i]  = 0;
            m_y[i]  = 0;
         end
         m_cnt    = 0;
         m_mode   = 0;
         m_lfsr   = SEED;
         exp_addr = '0;
         exp_mask = '0;
         sb.delete();
      end else begin
         r     = int'(row);
         c     = int'(col);
         hit_i = -1;
         for (int i = 0; i < NC; i++) begin
            if (hit_i < 0 && m_on[i] && r >= CTOP + m_y[i] && r < CTOP + m_y[i] + CH
                && c >= m_x[i] - CW && c < m_x[i]) begin
               hit_i = i;
            end
         end
         pix = 1'b0;
         if (hit_i >= 0) begin
            a        = (r - CTOP - m_y[hit_i]) * CW + (c - (m_x[hit_i] - CW));
            exp_addr = 12'(a);
            pix      = rom_bits[a];
         end
         sb.push_back('{cyc + 2, pix ? FG : BG, pix});

         first_free = -1;
         for (int i = NC - 1; i >= 0; i--) begin
            if (!m_on[i]) first_free = i;
         end
         do_spawn = enable && m_mode == 2 && first_free >= 0;

         if (!enable) begin
            m_mode = 0;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            if (frame_tick) begin
               if (m_cnt == GAP - 1) begin
                  m_cnt  = 0;
                  m_mode = 2;
               end else begin
                  m_cnt++;
               end
            end
         end else if (first_free >= 0) begin
            m_mode = 1;
         end

         if (frame_tick && enable) begin
            for (int i = 0; i < NC; i++) begin
               if (m_on[i]) begin
                  if (m_x[i] <= SPD) m_on[i] = 1'b0;
                  else m_x[i] = m_x[i] - SPD;
               end
            end
         end

         if (do_spawn) begin
            m_on[first_free] = 1'b1;
            m_x[first_free]  = SW + CW;
            m_y[first_free]  = int'(m_lfsr[4:0]);
         end

         if (frame_tick) begin
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else m_lfsr = m_lfsr >> 1;
         end

         for (int i = 0; i < NC; i++) exp_mask[i] = m_on[i];
         cyc++;
      end
   end

   // Monitor: compares slot state and ROM address every clock, and pops
   // each predicted pixel once its two-clock latency has elapsed.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && cyc > 0) begin
         check("active_mask", 32'(active_mask), 32'(exp_mask));
         check("rom_addr", 32'(rom_addr), 32'(exp_addr));
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due == cyc) begin
               check("d_out", 32'(d_out), 32'(e.d));
               check("opaque", 32'(opaque), 32'(e.o));
            end
         end
      end
   end

   // Scan position biased toward the cloud band so hits are frequent.
   task automatic drive_pixel();
      if ($urandom_range(0, 7) == 0) row = 9'($urandom_range(0, 479));
      else row = 9'($urandom_range(CTOP - 4, CTOP + 31 + CH + 2));
      col = 10'($urandom_range(0, 1023));
   endtask

   // Random run: frame ticks every 2-4 clocks, occasional pauses.
   task automatic apply_stimulus(input int n_cycles);
      int gap_left;
      int off_left;
      gap_left = 1;
      off_left = 0;
      for (int n = 0; n < n_cycles; n++) begin
         @(negedge clk);
         drive_pixel();
         gap_left--;
         frame_tick = (gap_left == 0);
         if (gap_left == 0) gap_left = $urandom_range(2, 4);
         if (off_left > 0) begin
            enable = 1'b0;
            off_left--;
         end else if ($urandom_range(0, 499) == 0) begin
            enable   = 1'b0;
            off_left = $urandom_range(5, 80);
         end else begin
            enable = 1'b1;
         end
      end
   endtask

   task automatic check_output_reset(input string tag);
      check({tag, "_mask"}, 32'(active_mask), 32'd0);
      check({tag, "_d_out"}, 32'(d_out), 32'(BG));
      check({tag, "_opaque"}, 32'(opaque), 32'd0);
      check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      frame_tick = 1'b0;
      row        = '0;
      col        = '0;
      for (int i = 0; i < 4096; i++) rom_bits[i] = 1'($urandom_range(0, 1));
      $display("[TB] cloud_layer bench start");

      repeat (3) @(negedge clk);
      check_output_reset("reset");

      // First spawn must wait for exactly GAP frame ticks.
      rst    = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      for (int t = 1; t <= GAP; t++) begin
         frame_tick = 1'b1;
         drive_pixel();
         @(negedge clk);
         frame_tick = 1'b0;
         drive_pixel();
         if (t == GAP - 1) check("no_early_spawn", 32'(active_mask), 32'd0);
         @(negedge clk);
      end
      check("first_spawn", 32'(active_mask), 32'd1);

      // Long random run: fills all slots, defers spawns, overlaps clouds.
      apply_stimulus(6000);

      // Paused game: clouds frozen and still drawn while ticks continue.
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         enable     = 1'b0;
         frame_tick = n[0];
         drive_pixel();
      end
      @(negedge clk);
      enable     = 1'b1;
      frame_tick = 1'b0;
      apply_stimulus(600);

      // Asynchronous reset in the middle of a line.
      @(negedge clk);
      check("clouds_before_reset", 32'(active_mask != '0), 32'd1);
      #2 rst = 1'b1;
      #1 check_output_reset("async_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1500);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
